// File: rtl/rv32_mem_pkg.sv
// Shared constants and types for the RV32I load/store bridge.
package rv32_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_DONE,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/lsu_mem_bridge_if.sv
// Core-side request/response and bus-side cycle signals of the load/store bridge.
interface lsu_mem_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_fault;
  logic        cpu_busy;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  // Bridge side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3, bus_ack, bus_rdata,
    output cpu_rdata, cpu_done, cpu_fault, cpu_busy,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );

  // Core + memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3, bus_ack, bus_rdata,
    input  cpu_rdata, cpu_done, cpu_fault, cpu_busy,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store replication/byte enables, access legality,
// and load lane extraction with sign/zero extension.
module lsu_lane_align
  import rv32_mem_pkg::*;
(
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  be,
  output logic        illegal,
  output logic        misaligned,
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_addr_lo,
  input  logic [31:0] rsp_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  always_comb begin
    st_wdata = req_wdata;
    be       = BE_WORD;
    case (req_funct3)
      F3_SB, F3_LBU: begin
        st_wdata = {4{req_wdata[7:0]}};
        be       = BE_BYTE << req_addr_lo;
      end
      F3_SH, F3_LHU: begin
        st_wdata = {2{req_wdata[15:0]}};
        be       = req_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      default: ;
    endcase
  end

  // Unsigned variants exist only for loads, so any store with funct3[2] set is illegal.
  always_comb begin
    illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                 (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    misaligned = ((req_funct3 == F3_LH || req_funct3 == F3_LHU) && req_addr_lo[0]) ||
                 ((req_funct3 == F3_LW) && (req_addr_lo != 2'b00));
  end

  always_comb begin
    lane    = rsp_rdata >> {rsp_addr_lo, 3'b000};
    ld_data = lane;
    case (rsp_funct3)
      F3_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
      F3_LBU:  ld_data = {24'h0, lane[7:0]};
      F3_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
      F3_LHU:  ld_data = {16'h0, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: turns core byte/half/word accesses into word-aligned bus
// cycles with byte enables, with fault reporting and a bus timeout.
module lsu_mem_bridge
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  lsu_mem_bridge_if.slave   io
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;

  logic [31:0] st_wdata;
  logic [3:0]  be;
  logic        illegal;
  logic        misaligned;
  logic [31:0] ld_data;

  lsu_lane_align u_align (
    .req_we      (io.cpu_we),
    .req_funct3  (io.cpu_funct3),
    .req_addr_lo (io.cpu_addr[1:0]),
    .req_wdata   (io.cpu_wdata),
    .st_wdata    (st_wdata),
    .be          (be),
    .illegal     (illegal),
    .misaligned  (misaligned),
    .rsp_funct3  (funct3_q),
    .rsp_addr_lo (addr_lo_q),
    .rsp_rdata   (io.bus_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      io.cpu_rdata <= '0;
      io.cpu_done  <= 1'b0;
      io.cpu_fault <= 1'b0;
      io.cpu_busy  <= 1'b0;
      io.bus_req   <= 1'b0;
      io.bus_we    <= 1'b0;
      io.bus_addr  <= '0;
      io.bus_wdata <= '0;
      io.bus_be    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.cpu_req) begin
            io.cpu_busy <= 1'b1;
            if (illegal || misaligned) begin
              state        <= ST_FAULT;
              io.cpu_done  <= 1'b1;
              io.cpu_fault <= 1'b1;
              io.cpu_rdata <= '0;
            end else begin
              state        <= ST_BUS;
              cnt          <= '0;
              funct3_q     <= io.cpu_funct3;
              addr_lo_q    <= io.cpu_addr[1:0];
              io.bus_req   <= 1'b1;
              io.bus_we    <= io.cpu_we;
              io.bus_addr  <= {io.cpu_addr[31:2], 2'b00};
              io.bus_wdata <= st_wdata;
              io.bus_be    <= be;
            end
          end
        end
        ST_BUS: begin
          cnt <= cnt + CNT_W'(1);
          // Ack is checked first so an ack on the last allowed cycle still completes cleanly.
          if (io.bus_ack) begin
            state        <= ST_DONE;
            io.bus_req   <= 1'b0;
            io.cpu_done  <= 1'b1;
            io.cpu_fault <= 1'b0;
            if (!io.bus_we) io.cpu_rdata <= ld_data;
          end else if (cnt == CNT_LAST) begin
            state        <= ST_DONE;
            io.bus_req   <= 1'b0;
            io.cpu_done  <= 1'b1;
            io.cpu_fault <= 1'b1;
            io.cpu_rdata <= '0;
          end
        end
        ST_DONE, ST_FAULT: begin
          state        <= ST_IDLE;
          io.cpu_done  <= 1'b0;
          io.cpu_fault <= 1'b0;
          io.cpu_busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
